// File: rtl/gpio_debounce.sv
// gpio_debounce: conditions raw asynchronous pins before the GPIO controller.
// Each line passes through a two-flop synchroniser. A per-line integration
// counter then accepts a new level only after NTICKS consecutive sample ticks
// of disagreement. A shared free-running prescaler generates those ticks.
//
// Ports:
//   i_clk    system clock, all logic on posedge
//   i_rst_n  synchronous active-low reset
//   i_gpio   raw asynchronous pin levels
//   o_gpio   debounced stable levels
//   o_rise   one-cycle pulse per bit on an accepted 0->1 transition
//   o_fall   one-cycle pulse per bit on an accepted 1->0 transition
//   o_int    one-cycle pulse when any rise/fall pulse is set
module gpio_debounce #(
  parameter int unsigned    NIN      = 16,
  parameter int unsigned    PRESCALE = 1000,
  parameter int unsigned    NTICKS   = 4,
  parameter logic [NIN-1:0] DEFAULT  = '0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [NIN-1:0] i_gpio,
  output logic [NIN-1:0] o_gpio,
  output logic [NIN-1:0] o_rise,
  output logic [NIN-1:0] o_fall,
  output logic           o_int
);

  localparam int unsigned CntW = (NTICKS > 1) ? $clog2(NTICKS) : 1;
  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NTICKS - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  logic [NIN-1:0]  sync_x_q;
  logic [NIN-1:0]  sync_q_q;
  logic [PreW-1:0] pre_q, pre_d;
  logic            tick;
  logic [CntW-1:0] cnt_q [NIN];
  logic [CntW-1:0] cnt_d [NIN];
  logic [NIN-1:0]  gpio_q, gpio_d;
  logic [NIN-1:0]  rise_q, rise_d;
  logic [NIN-1:0]  fall_q, fall_d;
  logic            int_q, int_d;

  // Shared prescaler: free-running, never restarted by input activity.
  always_comb begin
    tick  = (pre_q == PreLast);
    pre_d = tick ? '0 : pre_q + PreW'(1);
  end

  // Per-line integration: any agreement cycle clears the count, so only
  // NTICKS uninterrupted mismatching ticks commit a new level.
  always_comb begin
    gpio_d = gpio_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < NIN; i++) begin
      if (sync_q_q[i] == gpio_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntLast) begin
          gpio_d[i] = sync_q_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync_q_q[i];
          fall_d[i] = ~sync_q_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    int_d = |{rise_d, fall_d};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_x_q <= DEFAULT;
      sync_q_q <= DEFAULT;
      pre_q    <= '0;
      cnt_q    <= '{default: '0};
      gpio_q   <= DEFAULT;
      rise_q   <= '0;
      fall_q   <= '0;
      int_q    <= 1'b0;
    end else begin
      sync_x_q <= i_gpio;
      sync_q_q <= sync_x_q;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      gpio_q   <= gpio_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      int_q    <= int_d;
    end
  end

  assign o_gpio = gpio_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_int  = int_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce. u_dut runs PRESCALE=1/NTICKS=4 for the
// latency, glitch, simultaneous and reset tests; u_dut2 runs PRESCALE=4/NTICKS=3
// for the bounce-then-settle test.
module tb_gpio_debounce;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [15:0] gpio, gpio2;
  logic [15:0] o_gpio, o_rise, o_fall;
  logic [15:0] o_gpio2, o_rise2, o_fall2;
  logic        o_int, o_int2;

  int n_checks = 0;
  int n_pass   = 0;

  // Bounce-test bookkeeping.
  int rise5_seen = 0;
  int fall2_seen = 0;
  int int2_seen  = 0;
  int cyc2       = 0;
  int rise5_cyc  = -1;

  always #5 clk = ~clk;

  gpio_debounce #(
    .NIN      (16),
    .PRESCALE (1),
    .NTICKS   (4),
    .DEFAULT  (16'h0000)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_gpio  (gpio),
    .o_gpio  (o_gpio),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_int   (o_int)
  );

  gpio_debounce #(
    .NIN      (16),
    .PRESCALE (4),
    .NTICKS   (3),
    .DEFAULT  (16'h0000)
  ) u_dut2 (
    .i_clk   (clk),
    .i_rst_n (rst2_n),
    .i_gpio  (gpio2),
    .o_gpio  (o_gpio2),
    .o_rise  (o_rise2),
    .o_fall  (o_fall2),
    .o_int   (o_int2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // After a change from old_v to new_v presented before the next edge, the
  // new level and its pulses appear after the 6th edge (2 sync + 4 ticks).
  task automatic watch(input string tag, input logic [15:0] old_v, input logic [15:0] new_v);
    logic [15:0] eg, er, ef;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      eg = (k >= 6) ? new_v : old_v;
      er = (k == 6) ? (new_v & ~old_v) : 16'h0000;
      ef = (k == 6) ? (old_v & ~new_v) : 16'h0000;
      chk($sformatf("%s.gpio@%0d", tag, k), o_gpio, eg);
      chk($sformatf("%s.rise@%0d", tag, k), o_rise, er);
      chk($sformatf("%s.fall@%0d", tag, k), o_fall, ef);
      chk($sformatf("%s.int@%0d", tag, k), 16'(o_int), (k == 6) ? 16'h0001 : 16'h0000);
    end
  endtask

  task automatic step2(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc2++;
      if (o_rise2[5]) begin
        rise5_seen++;
        rise5_cyc = cyc2;
      end
      if (o_fall2 != 16'h0000) fall2_seen++;
      if (o_int2) int2_seen++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    gpio   = 16'hFFFF;
    gpio2  = 16'h0000;

    // Reset state with pins high.
    repeat (3) @(negedge clk);
    chk("rst.gpio", o_gpio, 16'h0000);
    chk("rst.rise", o_rise, 16'h0000);
    chk("rst.fall", o_fall, 16'h0000);
    chk("rst.int", 16'(o_int), 16'h0000);
    chk("rst2.gpio", o_gpio2, 16'h0000);

    // Release: pins differing from DEFAULT debounce normally.
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    watch("release", 16'h0000, 16'hFFFF);

    gpio = 16'h0000;
    watch("all_fall", 16'hFFFF, 16'h0000);

    // Clean edge on bit 3, then back.
    gpio = 16'h0008;
    watch("clean_rise", 16'h0000, 16'h0008);
    gpio = 16'h0000;
    watch("clean_fall", 16'h0008, 16'h0000);

    // Glitch: bit 0 high for 3 clocks is never accepted.
    gpio = 16'h0001;
    repeat (3) @(negedge clk);
    gpio = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("glitch.gpio@%0d", k), o_gpio, 16'h0000);
      chk($sformatf("glitch.pulse@%0d", k), o_rise | o_fall | 16'(o_int), 16'h0000);
    end

    // Simultaneous opposite transitions on two bits.
    gpio = 16'h8000;
    watch("pre_sim", 16'h0000, 16'h8000);
    gpio = 16'h0001;
    watch("sim", 16'h8000, 16'h0001);
    gpio = 16'h0000;
    watch("post_sim", 16'h0001, 16'h0000);

    // Reset with cnt[2]==2 (edges 0..3 after the change), then re-debounce.
    gpio = 16'h0004;
    repeat (4) @(negedge clk);
    chk("midrst.pre_gpio", o_gpio, 16'h0000);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst.gpio@%0d", k), o_gpio, 16'h0000);
      chk($sformatf("midrst.pulse@%0d", k), o_rise | o_fall | 16'(o_int), 16'h0000);
    end
    rst_n = 1'b1;
    watch("midrst_redo", 16'h0000, 16'h0004);

    // Bounce then settle on u_dut2, bit 5.
    for (int r = 0; r < 4; r++) begin
      gpio2 = 16'h0020;
      step2(5);
      gpio2 = 16'h0000;
      step2(5);
    end
    chk("bounce.gpio_before", o_gpio2, 16'h0000);
    chk("bounce.rise_before", 16'(rise5_seen), 16'h0000);
    gpio2 = 16'h0020;
    cyc2  = 0;
    step2(30);
    chk("bounce.gpio_after", o_gpio2, 16'h0020);
    chk("bounce.rise_count", 16'(rise5_seen), 16'h0001);
    chk("bounce.fall_count", 16'(fall2_seen), 16'h0000);
    chk("bounce.int_count", 16'(int2_seen), 16'h0001);
    chk("bounce.latency_in_10_14",
        ((rise5_cyc >= 10) && (rise5_cyc <= 14)) ? 16'h0001 : 16'h0000, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
